piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
- Upstream stage for the serial sequence detectors (e.g. the 1011 Moore detector); converts parallel words into the 1-bit stream they consume on their `in` port.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Optionally inserts idle gap cycles and an even-parity bit.
- Drives ser_out straight into a detector's `in`; ser_valid qualifies each bit for downstream counters.

Parameters:
- WIDTH, 8, word length in bits (legal range 2..32).
- GAP, 0, idle cycles inserted after each word before load_ready returns high (legal range 0..15).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- load_data  input  WIDTH  parallel word; sampled only on the accept edge.
- load_valid  input  1  upstream has a word.
- load_ready  output  1  block can accept a word (registered).
- ser_out  output  1  serial bit; 0 whenever ser_valid=0.
- ser_valid  output  1  ser_out carries a data or parity bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse coincident with the final serial bit of a word.

Behaviour:
- Reset (async assert, any state): state=IDLE, shift register=0, bit counter=0, gap counter=0, ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1. An in-flight word is discarded and no done is produced.
- Reset deassertion: operation starts at the next rising edge.
- All outputs are registered; there are no combinational input-to-output paths.
- Accept: the word is accepted at the edge where load_valid=1 and load_ready=1. load_ready=1 only in IDLE.
- Latency: accept at edge N; bit[WIDTH-1] is on ser_out with ser_valid=1 during cycle N+1; bit[0] during cycle N+WIDTH.
- FSM states: IDLE, SHIFT, PARITY, GAP.
  - IDLE -> SHIFT on accept. Otherwise stay in IDLE with ser_valid=0 and ser_out=0.
  - SHIFT: each edge shifts left; bit counter counts WIDTH-1 down to 0.
  - At count 0, SHIFT exits to PARITY if the parity feature is compiled in; else to GAP if GAP>0; else to IDLE.
  - PARITY: one cycle, ser_valid=1, ser_out = XOR of the accepted word (even parity). Then to GAP if GAP>0, else IDLE.
  - GAP: exactly GAP cycles with ser_valid=0, ser_out=0, busy=1. Then to IDLE.
- done=1 in the same cycle as the last valid serial bit (bit[0], or the parity bit when enabled).
- Minimum word spacing: one IDLE cycle plus GAP cycles (ser_valid=0) between consecutive words. Back-to-back streaming without an idle cycle is not supported.
- load_valid while busy: ignored; load_ready=0. load_data changes after accept have no effect on the bits being sent.
- load_valid deasserted in IDLE: no action.
- Counter widths: bit counter is $clog2(WIDTH) bits; gap counter is 4 bits. Neither counter wraps; each is reloaded on its state entry.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined: PARITY state is present; each word occupies WIDTH+1 valid cycles; done aligns with the parity bit.
- Undefined: PARITY state and parity logic are absent; each word occupies WIDTH valid cycles; done aligns with bit[0].

Decomposition:
- Shared package ser_pkg:
  - state enum typedef ser_state_t {IDLE, SHIFT, PARITY, GAP};
  - constant GAP_CNT_W=4.
- No sub-module: the shift register, counters and FSM fit in one module.
- Optionally, a separate top-level testbench wrapper chains this block to the 1011 detector.

Test Plan:
- WIDTH=8, GAP=0, parity off; accept 8'hB0 -> ser_out=1,0,1,1,0,0,0,0 on cycles N+1..N+8 with ser_valid=1; done only at N+8; load_ready=1 again at N+9.
- WIDTH=4, chained to the 1011 detector; load 4'hB -> detector `out`=1 one cycle after bit[0] is sampled (Moore output from state s1011); load 4'hA -> detector `out` stays 0.
- Hold load_valid=1 continuously, GAP=2, words 8'hFF then 8'h00 -> 8 ones, then 3 cycles ser_valid=0 (2 GAP + 1 IDLE), then 8 zeros; exactly two done pulses.
- Assert rst asynchronously mid-cycle after 3 bits of 8'hB0 -> ser_valid/ser_out/busy go to 0 before the next edge; no done. Next word 8'h80 serializes from its MSB.
- Change load_data and pulse load_valid during SHIFT -> load_ready=0, the original word completes unchanged, and the new value is not transmitted unless re-presented in IDLE.
- SER_PARITY_EN defined, 8'hB0 (three ones) -> 9th valid bit=1, done on the 9th bit; 8'hB4 (four ones) -> parity bit=0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and helpers for the parallel-in / serial-out bit serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } ser_state_t;

  localparam int GAP_CNT_W = 4;

  // Even parity over a zero-extended word: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// Accepts a WIDTH-bit word over valid/ready and shifts it out MSB-first, one bit per clock.
// Optional build macro SER_PARITY_EN appends an even-parity bit after bit[0].
module piso_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  import ser_pkg::*;

  localparam int                    BCW      = $clog2(WIDTH);
  localparam logic [BCW-1:0]        BIT_LOAD = BCW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : {GAP_CNT_W{1'b0}};
  localparam bit                    HAS_GAP  = (GAP > 0);

  ser_state_t           state_r;
  ser_state_t           next_state_s;
  logic [WIDTH-1:0]     shift_r;
  logic [WIDTH-1:0]     shift_nxt_s;
  logic [BCW-1:0]       bit_cnt_r;
  logic [BCW-1:0]       bit_cnt_nxt_s;
  logic [GAP_CNT_W-1:0] gap_cnt_r;
  logic [GAP_CNT_W-1:0] gap_cnt_nxt_s;
  logic                 accept_s;
  logic                 last_bit_s;
  logic                 ser_out_nxt_s;
  logic                 ser_valid_nxt_s;
  logic                 busy_nxt_s;
  logic                 done_nxt_s;
  logic                 load_ready_nxt_s;

`ifdef SER_PARITY_EN
  logic                 parity_r;
  logic                 parity_nxt_s;
`endif

  assign accept_s   = (state_r == IDLE) && load_valid && load_ready;
  assign last_bit_s = (bit_cnt_r == {BCW{1'b0}});

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = SHIFT;
        else          next_state_s = IDLE;
      end
      SHIFT: begin
        if (!last_bit_s) begin
          next_state_s = SHIFT;
        end else begin
`ifdef SER_PARITY_EN
          next_state_s = PARITY;
`else
          if (HAS_GAP) next_state_s = ser_pkg::GAP;
          else         next_state_s = IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        if (HAS_GAP) next_state_s = ser_pkg::GAP;
        else         next_state_s = IDLE;
      end
`endif
      ser_pkg::GAP: begin
        if (gap_cnt_r == {GAP_CNT_W{1'b0}}) next_state_s = IDLE;
        else                                next_state_s = ser_pkg::GAP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Shift register and counter updates; counters reload on entry to their state.
  always_comb begin
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    gap_cnt_nxt_s = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_nxt_s   = load_data;
          bit_cnt_nxt_s = BIT_LOAD;
        end else begin
          shift_nxt_s   = shift_r;
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
      SHIFT: begin
        if (!last_bit_s) begin
          shift_nxt_s   = shift_r << 1;
          bit_cnt_nxt_s = bit_cnt_r - BCW'(1);
        end else begin
          gap_cnt_nxt_s = GAP_LOAD;
        end
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        gap_cnt_nxt_s = GAP_LOAD;
      end
`endif
      ser_pkg::GAP: begin
        if (gap_cnt_r != {GAP_CNT_W{1'b0}}) gap_cnt_nxt_s = gap_cnt_r - GAP_CNT_W'(1);
        else                                gap_cnt_nxt_s = gap_cnt_r;
      end
      default: begin
        shift_nxt_s   = shift_r;
        bit_cnt_nxt_s = bit_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
      end
    endcase
  end

`ifdef SER_PARITY_EN
  // Parity of the accepted word is captured once so later load_data changes cannot leak in.
  always_comb begin
    if (accept_s) parity_nxt_s = even_parity(32'(load_data));
    else          parity_nxt_s = parity_r;
  end

  // Parity holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= parity_nxt_s;
    end
  end
`endif

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {BCW{1'b0}};
      gap_cnt_r <= {GAP_CNT_W{1'b0}};
    end else begin
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

  // Output decode from the upcoming state, so every output leaves a flop.
  always_comb begin
    ser_valid_nxt_s  = 1'b0;
    ser_out_nxt_s    = 1'b0;
    done_nxt_s       = 1'b0;
    busy_nxt_s       = (next_state_s != IDLE);
    load_ready_nxt_s = (next_state_s == IDLE);
    case (next_state_s)
      SHIFT: begin
        ser_valid_nxt_s = 1'b1;
        ser_out_nxt_s   = shift_nxt_s[WIDTH-1];
`ifndef SER_PARITY_EN
        done_nxt_s      = (bit_cnt_nxt_s == {BCW{1'b0}});
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: begin
        ser_valid_nxt_s = 1'b1;
        ser_out_nxt_s   = parity_nxt_s;
        done_nxt_s      = 1'b1;
      end
`endif
      IDLE: begin
        ser_valid_nxt_s = 1'b0;
        ser_out_nxt_s   = 1'b0;
      end
      ser_pkg::GAP: begin
        ser_valid_nxt_s = 1'b0;
        ser_out_nxt_s   = 1'b0;
      end
      default: begin
        ser_valid_nxt_s = 1'b0;
        ser_out_nxt_s   = 1'b0;
        done_nxt_s      = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      ser_out    <= ser_out_nxt_s;
      ser_valid  <= ser_valid_nxt_s;
      busy       <= busy_nxt_s;
      done       <= done_nxt_s;
      load_ready <= load_ready_nxt_s;
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed self-checking bench: an 8-bit/GAP=0 instance and an 8-bit/GAP=2 instance.
module tb_piso_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] ld_data;
  logic       ld_valid;
  logic       ld_ready, so, sv, busy, done;
  logic [7:0] g_data;
  logic       g_valid;
  logic       g_ready, g_so, g_sv, g_busy, g_done;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] word;
    logic       par;
  } vec_t;

  piso_bit_serializer #(.WIDTH(8), .GAP(0)) dut (
    .clk(clk), .rst(rst), .load_data(ld_data), .load_valid(ld_valid),
    .load_ready(ld_ready), .ser_out(so), .ser_valid(sv), .busy(busy), .done(done)
  );

  piso_bit_serializer #(.WIDTH(8), .GAP(2)) dut_g (
    .clk(clk), .rst(rst), .load_data(g_data), .load_valid(g_valid),
    .load_ready(g_ready), .ser_out(g_so), .ser_valid(g_sv), .busy(g_busy), .done(g_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word on the GAP=0 instance and check every serial cycle.
  task automatic send_word(input logic [7:0] w, input logic p, input bit glitch);
    int  n;
    logic eb;
    n = 0;
    while (ld_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", ld_ready, 1);
    ld_data  = w;
    ld_valid = 1'b1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      if (i < 8) eb = w[7-i];
      else       eb = p;
      check("ser_valid", sv, 1);
      check("ser_out", so, eb);
      check("done", done, (i == NB - 1) ? 1 : 0);
      check("busy", busy, 1);
      check("ready_low", ld_ready, 0);
      if (i == 0) ld_data = ~w;
      ld_valid = (glitch && i == 2) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    check("post_valid", sv, 0);
    check("post_out", so, 0);
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_ready", ld_ready, 1);
  endtask

  vec_t vecs[8];
  int   dcnt;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ld_data  = 8'h00;
    ld_valid = 1'b0;
    g_data   = 8'h00;
    g_valid  = 1'b0;

    vecs[0] = '{8'hB0, 1'b1};
    vecs[1] = '{8'hB4, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h00, 1'b0};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h5A, 1'b0};
    vecs[7] = '{8'hC3, 1'b0};

    #12;
    check("rst_ready", ld_ready, 1);
    check("rst_valid", sv, 0);
    check("rst_out", so, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_g_ready", g_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_valid", sv, 0);
    check("idle_ready", ld_ready, 1);

    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].word, vecs[v].par, 1'b0);
    end

    // Mid-shift load attempt with different data must be ignored.
    send_word(8'hB0, 1'b1, 1'b1);
    @(negedge clk);
    check("glitch_not_sent", sv, 0);

    // Async reset three bits into a word.
    ld_data  = 8'hB0;
    ld_valid = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_bit", so, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", sv, 0);
    check("arst_out", so, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_ready", ld_ready, 1);
    @(negedge clk);
    rst  = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 || sv === 1'b1) dcnt++;
    end
    check("no_done_after_rst", dcnt, 0);
    send_word(8'h80, 1'b1, 1'b0);

    // GAP=2 with load_valid held high: FF, 3 idle cycles, then 00.
    g_data  = 8'hFF;
    g_valid = 1'b1;
    dcnt    = 0;
    for (int k = 0; k < 2 * NB + 3; k++) begin
      @(negedge clk);
      if (k < NB) begin
        check("g1_valid", g_sv, 1);
        check("g1_out", g_so, (k < 8) ? 1 : 0);
      end else if (k < NB + 3) begin
        check("gap_valid", g_sv, 0);
        check("gap_out", g_so, 0);
        check("gap_busy", g_busy, (k < NB + 2) ? 1 : 0);
        check("gap_ready", g_ready, (k == NB + 2) ? 1 : 0);
      end else begin
        check("g2_valid", g_sv, 1);
        check("g2_out", g_so, 0);
      end
      check("g_done", g_done, (k == NB - 1 || k == 2 * NB + 2) ? 1 : 0);
      if (g_done === 1'b1) dcnt++;
      if (k == 0) g_data = 8'h00;
    end
    g_valid = 1'b0;
    check("g_done_count", dcnt, 2);
    repeat (4) @(negedge clk);
    check("g_final_ready", g_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
